// File: rtl/seq_gen.sv
// Serial pattern generator: shifts the top len bits of a captured pattern out MSB-first,
// repeating the pass rep+1 times, then pulses done. Illegal lengths are rejected with err.
module seq_gen #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clock,
    input  logic             reset_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CW-1:0]    len_in,
    input  logic [3:0]       rep_in,
    output logic             seq_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             err_out
);

    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [BW-1:0]    len_reg, len_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [3:0]       pass_cnt_reg, pass_cnt_next;

    logic seq_reg, valid_reg, busy_reg, done_reg, err_reg;
    logic seq_next, valid_next, busy_next, done_next, err_next;

    logic len_ok;
    logic start_ok;
    logic last_bit;
    logic last_pass;

    assign len_ok    = (len_in != '0) && (32'(len_in) <= 32'(WIDTH));
    assign start_ok  = start_in && len_ok;
    assign last_bit  = (bit_cnt_reg == BW'(1));
    assign last_pass = (pass_cnt_reg == 4'd0);

    // All state, datapath and output registers; outputs lag the FSM by one edge.
    always_ff @(posedge clock) begin
        if (reset_in) begin
            state_reg    <= IDLE;
            data_reg     <= '0;
            shift_reg    <= '0;
            len_reg      <= '0;
            bit_cnt_reg  <= '0;
            pass_cnt_reg <= '0;
            seq_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            shift_reg    <= shift_next;
            len_reg      <= len_next;
            bit_cnt_reg  <= bit_cnt_next;
            pass_cnt_reg <= pass_cnt_next;
            seq_reg      <= seq_next;
            valid_reg    <= valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    // Next state plus datapath: capture on accept, shift per bit, reload between passes.
    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        shift_next    = shift_reg;
        len_next      = len_reg;
        bit_cnt_next  = bit_cnt_reg;
        pass_cnt_next = pass_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next    = SEND;
                    data_next     = data_in;
                    shift_next    = data_in;
                    len_next      = BW'(len_in);
                    bit_cnt_next  = BW'(len_in);
                    pass_cnt_next = rep_in;
                end
            end
            SEND: begin
                if (last_bit && !last_pass) begin
                    shift_next    = data_reg;
                    bit_cnt_next  = len_reg;
                    pass_cnt_next = pass_cnt_reg - 4'd1;
                end else begin
                    shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
                    bit_cnt_next = bit_cnt_reg - BW'(1);
                    if (last_bit) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        seq_next   = 1'b0;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                err_next = start_in && !len_ok;
            end
            SEND: begin
                seq_next   = shift_reg[WIDTH-1];
                valid_next = 1'b1;
                busy_next  = 1'b1;
            end
            DONE: begin
                done_next = 1'b1;
                busy_next = 1'b1;
            end
            default: begin
                seq_next = 1'b0;
            end
        endcase
    end

    assign seq_out   = seq_reg;
    assign valid_out = valid_reg;
    assign busy_out  = busy_reg;
    assign done_out  = done_reg;
    assign err_out   = err_reg;

endmodule
